cla_nibble_sequencer: RTL and testbench
=======================================

Name: cla_nibble_sequencer

Overview:
- Multi-cycle WIDTH-bit add/subtract engine built around one shared 4-bit carry-lookahead slice.
- The slice has 4-bit A/B inputs, a cin input, a 4-bit sum output, and group propagate (pg) and group generate (gg) outputs.
- The sequencer captures operands, feeds the slice one nibble per cycle from LSB to MSB, and registers the inter-nibble carry as gg | (pg & carry).
- It returns the result through a valid/ready handshake. It is the area-reduced alternative to the 16-bit parallel CLA adders.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NNIB, WIDTH/4, number of slice passes per operation (derived, not overridable).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  requester presents an operation.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = A - B, 0 = A + B.
- cin  input  1  carry-in for add; borrow-complement for subtract (see Behaviour).
- out_valid  output  1  result is available.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1; for subtract, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at an edge, in any state):
  - state goes to IDLE; nibble counter = 0; carry register = 0.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0, busy = 0, in_ready = 1 on the following cycle.
  - Any in-flight operation is discarded with no output.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: capture opA = a; capture opB = sub ? ~b : b; carry = cin ^ sub; counter = 0; go to RUN.
  - Subtract with cin = 0 therefore gives A - B; subtract with cin = 1 gives A - B - 1.
- State RUN, one slice pass per cycle, for nibble k = counter:
  - Slice inputs: opA[4k+3:4k], opB[4k+3:4k], carry.
  - Working sum nibble k receives the slice sum.
  - carry <= gg | (pg & carry).
  - counter increments.
  - When k = NNIB-1, on that edge:
    - sum <= full working sum including the final nibble.
    - cout <= final carry.
    - ovf <= (opA[WIDTH-1] == opB[WIDTH-1]) & (result[WIDTH-1] != opA[WIDTH-1]).
    - Go to DONE.
- State DONE:
  - out_valid = 1.
  - sum, cout and ovf are held stable until out_ready is sampled high.
  - On out_valid & out_ready at an edge: go to IDLE and drop out_valid.
- Output register rules:
  - sum, cout and ovf change only on the edge entering DONE, or on reset.
  - They otherwise retain the last result; this holds in IDLE too.
- in_ready = 0 in RUN and DONE. in_valid is ignored there, with no queueing.
- Latency: the accept edge is cycle 0; out_valid is high from the edge at cycle NNIB onward (4 cycles for WIDTH = 16).
- Throughput: one operation per NNIB+2 cycles minimum, when out_ready is held high.
- Arithmetic is modulo 2^WIDTH. The counter must never index beyond nibble NNIB-1.
- Input changes after capture have no effect on the operation in flight.

Test Plan:
- Basic add: a=0x1234, b=0x4321, sub=0, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge; in_ready=0 during RUN.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Signed overflow: a=0x7FFF + b=0x0001 -> sum=0x8000, ovf=1, cout=0. a=0x8000 + b=0x8000 -> sum=0x0000, ovf=1, cout=1.
- Subtract: a=0x0005 - b=0x0007 (sub=1, cin=0) -> sum=0xFFFE, cout=0, ovf=0. a=0x8000 - b=0x0001 -> sum=0x7FFF, cout=1, ovf=1. a=0x0010, b=0x0001, sub=1, cin=1 -> sum=0x000E.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid/a/b -> sum/cout/ovf stable, in_ready=0, no new capture; out_ready=1 -> IDLE next cycle, and the next operation is accepted normally.
- Reset mid-operation: assert rst_n=0 for 1 cycle at RUN nibble 2 -> next cycle IDLE, out_valid=0, sum=0, in_ready=1; a following 0x0001+0x0001 yields 0x0002.

Source files
------------

// File: rtl/cla_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// cla_nibble_sequencer
//
// Multi-cycle WIDTH-bit add/subtract engine built around a single shared
// 4-bit carry-lookahead slice. An accepted operation is processed one nibble
// per cycle, from the least significant nibble to the most significant one.
// The result is returned through a valid/ready handshake.
//
// Ports:
//   clk        single clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   requester presents an operation
//   in_ready   block can accept an operation this cycle (IDLE only)
//   a, b       WIDTH-bit operands
//   sub        1 = a - b, 0 = a + b
//   cin        carry-in for add; for subtract, cin = 1 also subtracts one
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result
//   cout       carry out of the top bit; for subtract, 1 = no borrow
//   ovf        signed two's-complement overflow
//   busy       high while an operation is running or waiting to be taken
//
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead slice. It produces the nibble sum and the group
// propagate/generate terms, which the sequencer uses to form the next carry.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // All internal carries are computed directly from cin, without rippling.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
  assign pg  = &p;
  assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

endmodule

module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NNIB = WIDTH / 4;
  localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] sum_full;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [CW+1:0]    base;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             pg;
  logic             gg;
  logic             carry_nxt;
  logic             accept;
  logic             last;

  // Bit offset of the nibble being processed this cycle.
  assign base  = {cnt, 2'b00};
  assign nib_a = opa[base +: 4];
  assign nib_b = opb[base +: 4];

  cla4_slice u_slice (
    .a   (nib_a),
    .b   (nib_b),
    .cin (carry),
    .sum (nib_sum),
    .pg  (pg),
    .gg  (gg)
  );

  assign carry_nxt = gg | (pg & carry);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == LAST);

  // Working sum with the current slice output merged in, so the final
  // nibble can be written to the result register on the same edge.
  always_comb begin
    sum_full = work;
    sum_full[base +: 4] = nib_sum;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, per-nibble datapath and result registers. The result
  // registers are written only on the edge that enters DONE, so they keep
  // the last result through IDLE and the next run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtraction is a + ~b + 1; cin = 1 removes the +1.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          work[base +: 4] <= nib_sum;
          carry           <= carry_nxt;
          if (last) begin
            sum  <= sum_full;
            cout <= carry_nxt;
            ovf  <= (opa[WIDTH-1] == opb[WIDTH-1]) &
                    (sum_full[WIDTH-1] != opa[WIDTH-1]);
            // Park the counter at zero so it never points past the top nibble.
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cla_nibble_sequencer
//
// Self-checking bench for cla_nibble_sequencer (WIDTH = 16). Directed cases
// and randomized operations are compared against an arithmetic reference
// model that works on plain integers.
// ---------------------------------------------------------------------------
module tb_cla_nibble_sequencer;

  localparam int W    = 16;
  localparam int NNIB = W / 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  cla_nibble_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic on the unsigned and signed values.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic msub, input logic mcin,
                                output logic [W-1:0] ms, output logic mco,
                                output logic mov);
    int ua, ub, sa, sb, t, st;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!msub) begin
      t   = ua + ub + int'(mcin);
      st  = sa + sb + int'(mcin);
      mco = (t >= (1 << W));
    end else begin
      t   = ua - ub - int'(mcin);
      st  = sa - sb - int'(mcin);
      mco = (t >= 0);
    end
    ms  = t[W-1:0];
    mov = (st > (1 << (W-1)) - 1) || (st < -(1 << (W-1)));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, latency, result, optional backpressure,
  // then the output handshake back to IDLE.
  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tsub, input logic tcin,
                               input int hold);
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    int           cyc;
    model(ta, tb, tsub, tcin, es, eco, eov);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    sub       = tsub;
    cin       = tcin;
    out_ready = 1'b0;
    stepCycle();
    // Scramble inputs after capture; they must not affect the operation.
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    sub      = 1'($urandom);
    cin      = 1'($urandom);
    cyc      = 0;
    while (!out_valid && cyc < 20) begin
      checkOutput("in_ready_run", 32'(in_ready), 32'd0);
      stepCycle();
      cyc++;
    end
    checkOutput("latency", 32'(cyc), 32'(NNIB));
    checkOutput("sum", 32'(sum), 32'(es));
    checkOutput("cout", 32'(cout), 32'(eco));
    checkOutput("ovf", 32'(ovf), 32'(eov));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      stepCycle();
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_sum", 32'(sum), 32'(es));
      checkOutput("hold_cout", 32'(cout), 32'(eco));
      checkOutput("hold_ovf", 32'(ovf), 32'(eov));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput("ack_valid", 32'(out_valid), 32'd0);
    checkOutput("ack_ready", 32'(in_ready), 32'd1);
    checkOutput("ack_busy", 32'(busy), 32'd0);
    checkOutput("idle_sum", 32'(sum), 32'(es));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases, the first one with backpressure in DONE.
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 6);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    applyStimulus(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0, 0);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0, 2);
    applyStimulus(16'h0010, 16'h0001, 1'b1, 1'b1, 0);

    // Reset during RUN at nibble 2: the operation must vanish.
    in_valid = 1'b1;
    a        = 16'hABCD;
    b        = 16'h1111;
    sub      = 1'b0;
    cin      = 1'b0;
    stepCycle();
    in_valid = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_sum", 32'(sum), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
